// File: rtl/seed_a_row_reader_if.sv
// seed_a_row_reader_if: bus bundle for the seed_A row reader.
//   cmd side     : cmd {count, rowStart}, cmd_isReady, cmd_canReceive
//   storage cmd  : st_cmd, st_cmd_isReady, st_cmd_canReceive
//   storage data : st_in, st_in_isReady, st_in_canReceive, st_in_isLast
//   message out  : out, out_isReady, out_canReceive, out_isLast
//   slave = the reader block, master = its environment.
interface seed_a_row_reader_if #(parameter int CountBits = 16);
  logic [16+CountBits-1:0] cmd;
  logic cmd_isReady;
  logic cmd_canReceive;
  logic st_cmd;
  logic st_cmd_isReady;
  logic st_cmd_canReceive;
  logic [63:0] st_in;
  logic st_in_isReady;
  logic st_in_canReceive;
  logic st_in_isLast;
  logic [63:0] out;
  logic out_isReady;
  logic out_canReceive;
  logic out_isLast;
  modport slave (
    input cmd, cmd_isReady, st_cmd_canReceive, st_in, st_in_isReady, st_in_isLast, out_canReceive,
    output cmd_canReceive, st_cmd, st_cmd_isReady, st_in_canReceive, out, out_isReady, out_isLast
  );
  modport master (
    output cmd, cmd_isReady, st_cmd_canReceive, st_in, st_in_isReady, st_in_isLast, out_canReceive,
    input cmd_canReceive, st_cmd, st_cmd_isReady, st_in_canReceive, out, out_isReady, out_isLast
  );
endinterface

// File: rtl/seed_a_row_reader.sv
// seed_a_row_reader: re-reads seed_A once per row and emits {row, seed_A} as three LE 64-bit words.
//   clk : clock
//   rst : synchronous reset, active low
//   bus : seed_a_row_reader_if.slave (command, storage read, message output)
module seed_a_row_reader #(parameter int CountBits = 16) (
  input logic clk,
  input logic rst,
  seed_a_row_reader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, REQ, W0, W1, TAIL} state_t;
  state_t state, state_n;
  logic [15:0] row, carry;
  logic [CountBits-1:0] remaining;
  logic [63:0] out_data;
  logic out_valid, out_last;
  logic can_load, cmd_x, st_cmd_x, st_in_x, tail_load;
  logic unused;
  assign unused = bus.st_in_isLast;
  // the output register may be refilled in the same cycle its word leaves
  assign can_load = ~out_valid | bus.out_canReceive;
  assign cmd_x = bus.cmd_isReady & bus.cmd_canReceive;
  assign st_cmd_x = bus.st_cmd_isReady & bus.st_cmd_canReceive;
  assign st_in_x = bus.st_in_isReady & bus.st_in_canReceive;
  assign tail_load = (state == TAIL) & can_load;
  assign bus.st_cmd = 1'b0;
  assign bus.out = out_data;
  assign bus.out_isReady = out_valid;
  assign bus.out_isLast = out_last;
  always_ff @(posedge clk)
    state <= !rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (cmd_x && bus.cmd[16 +: CountBits] != '0) state_n = REQ;
      REQ: if (st_cmd_x) state_n = W0;
      W0: if (st_in_x) state_n = W1;
      W1: if (st_in_x) state_n = TAIL;
      TAIL: if (can_load) state_n = remaining == CountBits'(1) ? IDLE : REQ;
      default: state_n = IDLE;
    endcase
  end
  // a new command waits until the previous run's tail word has left
  always_comb begin
    bus.cmd_canReceive = (state == IDLE) && !out_valid;
    bus.st_cmd_isReady = state == REQ;
    bus.st_in_canReceive = ((state == W0) || (state == W1)) && can_load;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      row <= '0;
      carry <= '0;
      remaining <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (out_valid && bus.out_canReceive) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
      if (cmd_x) begin
        row <= bus.cmd[15:0];
        remaining <= bus.cmd[16 +: CountBits];
      end
      // top 16 bits of each seed word spill into the next message word
      if (st_in_x) begin
        out_data <= {bus.st_in[47:0], state == W0 ? row : carry};
        out_valid <= 1'b1;
        out_last <= 1'b0;
        carry <= bus.st_in[63:48];
      end
      if (tail_load) begin
        out_data <= {48'b0, carry};
        out_valid <= 1'b1;
        out_last <= 1'b1;
        remaining <= remaining - CountBits'(1);
        row <= row + 16'd1;
      end
    end
  end
endmodule
